uart_dl_master: RTL and testbench

UART download master that drives the m1 (high-priority) master port of the RIB bus. It receives 8N1 serial bytes, packs every four into a little-endian 32-bit word, and issues a one-cycle write at an auto-incrementing address. Each write request stalls the pipeline through the bus's hold logic. The block loads program images into memory while the core is held off.

---
 rtl/uart_dl_master.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_dl_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dl_master.sv
// uart_dl_master
//   UART download master for the m1 (high-priority) port of the RIB bus.
//   Receives 8N1 serial bytes, packs every four into a little-endian 32-bit
//   word and issues a single-cycle write at an auto-incrementing address,
//   so a program image can be streamed into memory while the core is held.
//
// Optional feature macro: DL_CHECKSUM_EN
//   defined   -> chksum_o is a modulo-256 sum of every valid byte received
//                since dl_en_i rose (bytes with framing errors excluded)
//   undefined -> chksum_o is tied to 8'h00 and no adder exists
//
// Parameters
//   CLK_DIV    clocks per UART bit (>= 16, so a write never overlaps the next byte)
//   BASE_ADDR  first write address (word aligned)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   uart_rx_i    asynchronous serial input, idle high
//   dl_en_i      download enable; low idles the receiver and flushes all state
//   m1_addr_o    bus write address (the write pointer)
//   m1_data_o    bus write data (last packed word)
//   m1_data_i    bus read data, not used by a write-only master
//   m1_req_o     bus request, one-cycle pulse per word
//   m1_we_o      bus write enable, pulses with m1_req_o
//   dl_busy_o    high while a frame or a partial word is in progress
//   word_cnt_o   words written since dl_en_i rose, saturating
//   frame_err_o  sticky framing error
//   chksum_o     running byte checksum (see macro above)

module uart_dl_master #(
    parameter int unsigned CLK_DIV   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_i,
    input  logic        dl_en_i,
    output logic [31:0] m1_addr_o,
    output logic [31:0] m1_data_o,
    input  logic [31:0] m1_data_i,
    output logic        m1_req_o,
    output logic        m1_we_o,
    output logic        dl_busy_o,
    output logic [15:0] word_cnt_o,
    output logic        frame_err_o,
    output logic [7:0]  chksum_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Word counter saturates instead of wrapping so a very long image
    // never reports a misleadingly small count.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    rx_state_t        state;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_d;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [1:0]       byte_idx;
    logic [23:0]      word_acc;

    logic             rx_fall;
    logic             stop_hit;
    logic             byte_ok;
    logic             unused_rd;

    // rx_d is the previous synchronized level, so a 1->0 step is an edge.
    assign rx_fall  = rx_d & ~rx_s2;
    assign stop_hit = (state == ST_STOP) && (baud_cnt == BIT_LAST);
    assign byte_ok  = dl_en_i && stop_hit && rx_s2;

    assign dl_busy_o = (state != ST_IDLE) || (byte_idx != 2'd0);

    // A write-only master never consumes read data.
    assign unused_rd = ^m1_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_d        <= 1'b1;
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            byte_idx    <= 2'd0;
            word_acc    <= 24'h0;
            m1_addr_o   <= BASE_ADDR;
            m1_data_o   <= 32'h0;
            m1_req_o    <= 1'b0;
            m1_we_o     <= 1'b0;
            word_cnt_o  <= 16'h0;
            frame_err_o <= 1'b0;
        end else begin
            rx_s1 <= uart_rx_i;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;

            // Request is a single-cycle pulse; the bus grants m1 without wait.
            m1_req_o <= 1'b0;
            m1_we_o  <= 1'b0;

            // Retire the write that is on the bus this cycle.
            if (m1_req_o) begin
                m1_addr_o  <= m1_addr_o + 32'd4;
                word_cnt_o <= sat_inc16(word_cnt_o);
            end

            if (!dl_en_i) begin
                // Flush overrides the pointer/count update above and any byte
                // completing this cycle; a pulse already on the bus still ends
                // normally because m1_req_o is only cleared, never extended.
                state       <= ST_IDLE;
                baud_cnt    <= '0;
                bit_cnt     <= 3'd0;
                byte_idx    <= 2'd0;
                word_acc    <= 24'h0;
                m1_addr_o   <= BASE_ADDR;
                word_cnt_o  <= 16'h0;
                frame_err_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_fall) begin
                            state    <= ST_START;
                            baud_cnt <= '0;
                            bit_cnt  <= 3'd0;
                        end
                    end

                    ST_START: begin
                        // Mid-start-bit check rejects glitches shorter than half a bit.
                        if (baud_cnt == HALF_LAST) begin
                            baud_cnt <= '0;
                            state    <= rx_s2 ? ST_IDLE : ST_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end

                    ST_DATA: begin
                        if (baud_cnt == BIT_LAST) begin
                            baud_cnt  <= '0;
                            shift_reg <= {rx_s2, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end

                    ST_STOP: begin
                        if (baud_cnt == BIT_LAST) begin
                            baud_cnt <= '0;
                            state    <= ST_IDLE;
                            if (rx_s2) begin
                                case (byte_idx)
                                    2'd0: word_acc[7:0]   <= shift_reg;
                                    2'd1: word_acc[15:8]  <= shift_reg;
                                    2'd2: word_acc[23:16] <= shift_reg;
                                    default: begin
                                        m1_data_o <= {shift_reg, word_acc};
                                        m1_req_o  <= 1'b1;
                                        m1_we_o   <= 1'b1;
                                    end
                                endcase
                                byte_idx <= byte_idx + 2'd1;
                            end else begin
                                // Bad stop bit: drop the byte, keep the lane index.
                                frame_err_o <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CNT_W'(1);
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    logic [7:0] chksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_q <= 8'h00;
        end else if (!dl_en_i) begin
            chksum_q <= 8'h00;
        end else if (byte_ok) begin
            chksum_q <= add_mod256(chksum_q, shift_reg);
        end
    end

    assign chksum_o = chksum_q;
`else
    logic unused_ck;
    assign unused_ck = byte_ok;
    assign chksum_o  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_dl_master.sv
// Directed bench for uart_dl_master (CLK_DIV=16, BASE_ADDR=32'h1000).
module tb_uart_dl_master;

    localparam int          DIV  = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef DL_CHECKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        uart_rx_i;
    logic        dl_en_i;
    logic [31:0] m1_addr_o;
    logic [31:0] m1_data_o;
    logic [31:0] m1_data_i;
    logic        m1_req_o;
    logic        m1_we_o;
    logic        dl_busy_o;
    logic [15:0] word_cnt_o;
    logic        frame_err_o;
    logic [7:0]  chksum_o;

    int total;
    int bad;

    // Write-pulse monitor, sampled on the falling edge.
    int          wr_cnt;
    int          run_len;
    int          last_run;
    logic [31:0] last_addr;
    logic [31:0] last_data;

    uart_dl_master #(.CLK_DIV(DIV), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_i   (uart_rx_i),
        .dl_en_i     (dl_en_i),
        .m1_addr_o   (m1_addr_o),
        .m1_data_o   (m1_data_o),
        .m1_data_i   (m1_data_i),
        .m1_req_o    (m1_req_o),
        .m1_we_o     (m1_we_o),
        .dl_busy_o   (dl_busy_o),
        .word_cnt_o  (word_cnt_o),
        .frame_err_o (frame_err_o),
        .chksum_o    (chksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        wr_cnt    = 0;
        run_len   = 0;
        last_run  = 0;
        last_addr = 32'h0;
        last_data = 32'h0;
    end

    always @(negedge clk) begin
        if (m1_req_o && m1_we_o) begin
            if (run_len == 0) begin
                wr_cnt    <= wr_cnt + 1;
                last_addr <= m1_addr_o;
                last_data <= m1_data_o;
            end
            run_len <= run_len + 1;
        end else begin
            if (run_len != 0) last_run <= run_len;
            run_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame plus 4 idle-high cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx_i = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            tick(DIV);
        end
        uart_rx_i = stop;
        tick(DIV);
        uart_rx_i = 1'b1;
        tick(4);
    endtask

    task automatic restart_dl();
        dl_en_i = 1'b0;
        tick(2);
        dl_en_i = 1'b1;
        tick(2);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        dl_en_i   = 1'b0;
        uart_rx_i = 1'b1;
        m1_data_i = 32'hDEAD_BEEF;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk("rst_req",   {31'h0, m1_req_o},    32'h0);
        chk("rst_we",    {31'h0, m1_we_o},     32'h0);
        chk("rst_data",  m1_data_o,            32'h0);
        chk("rst_addr",  m1_addr_o,            BASE);
        chk("rst_busy",  {31'h0, dl_busy_o},   32'h0);
        chk("rst_wcnt",  {16'h0, word_cnt_o},  32'h0);
        chk("rst_ferr",  {31'h0, frame_err_o}, 32'h0);
        chk("rst_ck",    {24'h0, chksum_o},    32'h0);

        // Single word 78 56 34 12
        dl_en_i = 1'b1;
        tick(2);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        chk("w1_busy_mid", {31'h0, dl_busy_o}, 32'h1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        tick(4);
        chk("w1_wrcnt", wr_cnt,               32'd1);
        chk("w1_waddr", last_addr,            32'h0000_1000);
        chk("w1_wdata", last_data,            32'h1234_5678);
        chk("w1_plen",  last_run,             32'd1);
        chk("w1_addr",  m1_addr_o,            32'h0000_1004);
        chk("w1_wcnt",  {16'h0, word_cnt_o},  32'd1);
        chk("w1_busy",  {31'h0, dl_busy_o},   32'h0);
        chk("w1_ck",    {24'h0, chksum_o},    CK_ON ? 32'h14 : 32'h0);

        // Two words 01..08 after a fresh enable
        restart_dl();
        chk("w2_addr0", m1_addr_o, BASE);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        tick(4);
        chk("w2_wdata0", last_data, 32'h0403_0201);
        chk("w2_waddr0", last_addr, 32'h0000_1000);
        for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b1);
        tick(4);
        chk("w2_wrcnt",  wr_cnt,              32'd3);
        chk("w2_wdata1", last_data,           32'h0807_0605);
        chk("w2_waddr1", last_addr,           32'h0000_1004);
        chk("w2_wcnt",   {16'h0, word_cnt_o}, 32'd2);
        chk("w2_ck",     {24'h0, chksum_o},   CK_ON ? 32'h24 : 32'h0);

        // 4-cycle glitch -> false start
        uart_rx_i = 1'b0;
        tick(4);
        uart_rx_i = 1'b1;
        tick(2);
        chk("gl_busy_hi", {31'h0, dl_busy_o},  32'h1);
        tick(20);
        chk("gl_busy_lo", {31'h0, dl_busy_o},  32'h0);
        chk("gl_wrcnt",   wr_cnt,              32'd3);
        chk("gl_wcnt",    {16'h0, word_cnt_o}, 32'd2);
        chk("gl_ferr",    {31'h0, frame_err_o}, 32'h0);

        // Framing error then AA BB CC DD
        restart_dl();
        send_byte(8'h55, 1'b0);
        chk("fe_ferr1", {31'h0, frame_err_o}, 32'h1);
        chk("fe_busy1", {31'h0, dl_busy_o},   32'h0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        tick(4);
        chk("fe_wrcnt", wr_cnt,               32'd4);
        chk("fe_wdata", last_data,            32'hDDCC_BBAA);
        chk("fe_waddr", last_addr,            32'h0000_1000);
        chk("fe_ferr2", {31'h0, frame_err_o}, 32'h1);
        chk("fe_ck",    {24'h0, chksum_o},    CK_ON ? 32'h0E : 32'h0);

        // Partial word discarded by dl_en_i drop
        restart_dl();
        chk("fl_ferr_clr", {31'h0, frame_err_o}, 32'h0);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        chk("fl_busy_part", {31'h0, dl_busy_o}, 32'h1);
        dl_en_i = 1'b0;
        tick(3);
        chk("fl_busy_off", {31'h0, dl_busy_o},  32'h0);
        chk("fl_wcnt_off", {16'h0, word_cnt_o}, 32'd0);
        chk("fl_ck_off",   {24'h0, chksum_o},   32'h0);
        dl_en_i = 1'b1;
        tick(2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        tick(4);
        chk("fl_wrcnt", wr_cnt,              32'd5);
        chk("fl_wdata", last_data,           32'h4433_2211);
        chk("fl_waddr", last_addr,           32'h0000_1000);
        chk("fl_wcnt",  {16'h0, word_cnt_o}, 32'd1);
        chk("fl_ck",    {24'h0, chksum_o},   CK_ON ? 32'hAA : 32'h0);

        // Reset during DATA bits of a byte, after a partial word
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                tick(60);
                rst = 1'b1;
                tick(1);
                chk("rs_req",  {31'h0, m1_req_o},    32'h0);
                chk("rs_data", m1_data_o,            32'h0);
                chk("rs_addr", m1_addr_o,            BASE);
                chk("rs_busy", {31'h0, dl_busy_o},   32'h0);
                chk("rs_wcnt", {16'h0, word_cnt_o},  32'd0);
                chk("rs_ck",   {24'h0, chksum_o},    32'h0);
                rst = 1'b0;
            end
        join
        tick(4);
        chk("rs_nowr", wr_cnt, 32'd5);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hD4, 1'b1);
        tick(4);
        chk("rs_wrcnt", wr_cnt,              32'd6);
        chk("rs_wdata", last_data,           32'hD4C3_B2A1);
        chk("rs_waddr", last_addr,           32'h0000_1000);
        chk("rs_plen",  last_run,            32'd1);
        chk("rs_wcnt2", {16'h0, word_cnt_o}, 32'd1);
        chk("rs_ck2",   {24'h0, chksum_o},   CK_ON ? 32'hEA : 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
